packet_allocator: RTL

Output-port allocator for the switch. It shares one output port among NREQ input ports at packet granularity. A winner is picked round-robin, and its grant is held until the last flit of its packet has transferred. Each flit transfer is gated by a credit counter that tracks free slots in the downstream buffer. The block sits between the input-port buffers and the crossbar select of one output port; the crossbar mux is steered by `grant_idx`.

---
 rtl/alloc_pkg.sv | 28 ++
 rtl/credit_counter.sv | 51 +++++
 rtl/packet_allocator.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alloc_pkg.sv
// ============================================================================
// alloc_pkg : shared types and width helpers for the packet allocator
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package alloc_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } alloc_state_t;

   // Index width that stays legal (>=1 bit) even for a range of one value
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int NREQ_DEF    = 4;
   localparam int CREDITS_DEF = 8;
   localparam int MAX_LEN_DEF = 16;
   localparam int LENW_DEF    = width_of(MAX_LEN_DEF);
   localparam int IDXW_DEF    = width_of(NREQ_DEF);
   localparam int CRW_DEF     = $clog2(CREDITS_DEF + 1);

endpackage

`default_nettype wire

// File: rtl/credit_counter.sv
// ============================================================================
// credit_counter : downstream free-slot tracker with sticky overflow flag
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module credit_counter #(
   parameter int CREDITS = 8,
   parameter int CW      = $clog2(CREDITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_consume,
   input  logic          i_return,
   output logic [CW-1:0] o_count,
   output logic          o_nonzero,
   output logic          o_err_credit
);

   localparam logic [CW-1:0] C_FULL = CW'(CREDITS);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   logic [CW-1:0] r_count;
   logic          r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= C_FULL;
         r_err   <= 1'b0;
      end else begin
         case ({i_consume, i_return})
            2'b10: begin
               if (r_count != '0) r_count <= r_count - C_ONE;
            end
            2'b01: begin
               // A return with the buffer already empty downstream is a protocol error
               if (r_count == C_FULL) r_err   <= 1'b1;
               else                   r_count <= r_count + C_ONE;
            end
            default: ;
         endcase
      end
   end

   assign o_count      = r_count;
   assign o_nonzero    = (r_count != '0);
   assign o_err_credit = r_err;

endmodule

`default_nettype wire

// File: rtl/packet_allocator.sv
// ============================================================================
// packet_allocator : round-robin, packet-granular, credit-gated output arbiter
//                    Optional watchdog enabled by ALLOC_WATCHDOG_EN
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module packet_allocator
   import alloc_pkg::*;
#(
   parameter  int NREQ      = NREQ_DEF,
   parameter  int CREDITS   = CREDITS_DEF,
   parameter  int MAX_LEN   = MAX_LEN_DEF,
   parameter  int WD_CYCLES = 256,
   localparam int LENW      = width_of(MAX_LEN),
   localparam int IDXW      = width_of(NREQ),
   localparam int CRW       = $clog2(CREDITS + 1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*LENW-1:0] len,
   input  logic [NREQ-1:0]      flit_valid,
   input  logic                 credit_return,
   output logic [NREQ-1:0]      grant,
   output logic [IDXW-1:0]      grant_idx,
   output logic                 grant_valid,
   output logic                 flit_accept,
   output logic [CRW-1:0]       credits,
   output logic                 err_credit,
   output logic                 abort
);

   alloc_state_t    r_state;
   logic [IDXW-1:0] r_last;
   logic [LENW-1:0] r_remaining;
   logic [NREQ-1:0] r_grant;
   logic [IDXW-1:0] r_idx;
   logic            r_gv;
   logic            r_abort;

   logic            w_pick_found;
   logic [IDXW-1:0] w_pick_idx;
   logic [IDXW-1:0] w_cand;
   logic [LENW-1:0] w_len [NREQ];
   logic            w_cr_nonzero;
   logic            w_accept;
   logic            w_wd_expire;

   for (genvar g = 0; g < NREQ; g++) begin : g_len
      assign w_len[g] = len[g*LENW +: LENW];
   end

   // Search starts one past the last winner so the last winner ranks lowest
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = IDXW'((int'(r_last) + k) % NREQ);
         if (!w_pick_found && req[w_cand]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand;
         end
      end
   end

   assign w_accept = (r_state == XFER) && flit_valid[r_idx] && w_cr_nonzero && !w_wd_expire;

   credit_counter #(
      .CREDITS (CREDITS),
      .CW      (CRW)
   ) u_credit (
      .clk          (CLK),
      .rst          (RST),
      .i_consume    (w_accept),
      .i_return     (credit_return),
      .o_count      (credits),
      .o_nonzero    (w_cr_nonzero),
      .o_err_credit (err_credit)
   );

`ifdef ALLOC_WATCHDOG_EN
   localparam int WDW = $clog2(WD_CYCLES + 1);

   logic [WDW-1:0] r_wd_cnt;

   // Counts only true source starvation; a credit stall is not the source's fault
   always_ff @(posedge CLK) begin
      if (RST || (r_state != XFER) || w_accept) begin
         r_wd_cnt <= '0;
      end else if (!flit_valid[r_idx] && (r_wd_cnt != WDW'(WD_CYCLES))) begin
         r_wd_cnt <= r_wd_cnt + WDW'(1);
      end
   end

   assign w_wd_expire = (r_state == XFER) && (r_wd_cnt == WDW'(WD_CYCLES));
`else
   assign w_wd_expire = (WD_CYCLES < 0);
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_last      <= IDXW'(NREQ - 1);
         r_remaining <= '0;
         r_grant     <= '0;
         r_idx       <= '0;
         r_gv        <= 1'b0;
         r_abort     <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_found) begin
                  r_state     <= XFER;
                  r_grant     <= NREQ'(1) << w_pick_idx;
                  r_idx       <= w_pick_idx;
                  r_gv        <= 1'b1;
                  r_remaining <= w_len[w_pick_idx];
                  r_last      <= w_pick_idx;
               end
            end
            XFER: begin
               if (w_wd_expire) begin
                  r_state <= IDLE;
                  r_grant <= '0;
                  r_gv    <= 1'b0;
                  r_abort <= 1'b1;
               end else if (w_accept) begin
                  if (r_remaining == '0) begin
                     r_state <= IDLE;
                     r_grant <= '0;
                     r_gv    <= 1'b0;
                  end else begin
                     r_remaining <= r_remaining - LENW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = r_gv;
   assign flit_accept = w_accept;
   assign abort       = r_abort;

endmodule

`default_nettype wire
